// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM inputs, MEM/WB outputs and debug dump stream of the MEM stage
interface mem_stage_if #(
    parameter int BUS_SIZE       = 32,
    parameter int MEM_ADDR_SIZE  = 5,
    parameter int DATA_ADDR_SIZE = 8
);
    // EX/MEM bundle
    logic                      enable;
    logic                      flush;
    logic [2:0]                mem_rd_src;
    logic [1:0]                mem_wr_src;
    logic                      mem_write;
    logic                      ex_wb;
    logic                      ex_mem_to_reg;
    logic                      ex_halt;
    logic [BUS_SIZE-1:0]       bus_b;
    logic [BUS_SIZE-1:0]       ex_alu_result;
    logic [MEM_ADDR_SIZE-1:0]  ex_addr_wr;

    // MEM/WB bundle
    logic                      wb;
    logic                      mem_to_reg;
    logic                      halt;
    logic [BUS_SIZE-1:0]       mem_result;
    logic [BUS_SIZE-1:0]       alu_result;
    logic [MEM_ADDR_SIZE-1:0]  addr_wr;

    // debug dump stream
    logic                      dump_start;
    logic                      dump_ready;
    logic                      dump_valid;
    logic [DATA_ADDR_SIZE-1:0] dump_addr;
    logic [BUS_SIZE-1:0]       dump_data;
    logic                      dump_done;

    modport master (
        output enable, flush, mem_rd_src, mem_wr_src, mem_write,
        output ex_wb, ex_mem_to_reg, ex_halt, bus_b, ex_alu_result, ex_addr_wr,
        input  wb, mem_to_reg, halt, mem_result, alu_result, addr_wr,
        output dump_start, dump_ready,
        input  dump_valid, dump_addr, dump_data, dump_done
    );

    modport slave (
        input  enable, flush, mem_rd_src, mem_wr_src, mem_write,
        input  ex_wb, ex_mem_to_reg, ex_halt, bus_b, ex_alu_result, ex_addr_wr,
        output wb, mem_to_reg, halt, mem_result, alu_result, addr_wr,
        input  dump_start, dump_ready,
        output dump_valid, dump_addr, dump_data, dump_done
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: byte-lane data memory, MEM/WB register, memory dump streamer
module mem_stage #(
    parameter int BUS_SIZE       = 32,
    parameter int MEM_ADDR_SIZE  = 5,
    parameter int DATA_ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave bus
);
    localparam int DEPTH = 1 << DATA_ADDR_SIZE;
    localparam logic [DATA_ADDR_SIZE-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        DUMP_IDLE,
        DUMP_SEND,
        DUMP_DONE
    } dump_state_t;

    logic [BUS_SIZE-1:0]       mem [DEPTH];

    logic [DATA_ADDR_SIZE-1:0] word_idx;
    logic [1:0]                byte_lane;
    logic [BUS_SIZE-1:0]       rd_word;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;
    logic [BUS_SIZE-1:0]       ld_data;
    logic [3:0]                st_mask;
    logic [BUS_SIZE-1:0]       st_data;
    logic                      st_en;

    logic                      wb_q;
    logic                      mem_to_reg_q;
    logic                      halt_q;
    logic [BUS_SIZE-1:0]       mem_result_q;
    logic [BUS_SIZE-1:0]       alu_result_q;
    logic [MEM_ADDR_SIZE-1:0]  addr_wr_q;

    dump_state_t               dump_state_q;
    dump_state_t               dump_state_d;
    logic [DATA_ADDR_SIZE-1:0] dump_idx_q;
    logic [DATA_ADDR_SIZE-1:0] dump_idx_d;
    logic                      dump_valid;
    logic                      dump_done;

    // Upper address bits beyond the array are dropped so accesses wrap.
    assign word_idx  = bus.ex_alu_result[DATA_ADDR_SIZE+1:2];
    assign byte_lane = bus.ex_alu_result[1:0];
    assign rd_word   = mem[word_idx];

    always_comb begin
        ld_byte = rd_word[{byte_lane, 3'b000} +: 8];
        ld_half = byte_lane[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = '0;
        if (bus.mem_rd_src[2]) begin
            ld_data = rd_word;
        end else begin
            case (bus.mem_rd_src[1:0])
                2'b00:   ld_data = {{(BUS_SIZE-8){ld_byte[7]}}, ld_byte};
                2'b01:   ld_data = {{(BUS_SIZE-8){1'b0}}, ld_byte};
                2'b10:   ld_data = {{(BUS_SIZE-16){ld_half[15]}}, ld_half};
                default: ld_data = {{(BUS_SIZE-16){1'b0}}, ld_half};
            endcase
        end
    end

    // Store data is replicated across lanes so the mask alone picks the target bytes.
    always_comb begin
        st_mask = 4'b1111;
        st_data = bus.bus_b;
        case (bus.mem_wr_src)
            2'b00: begin
                st_mask = 4'b0001 << byte_lane;
                st_data = {4{bus.bus_b[7:0]}};
            end
            2'b01: begin
                st_mask = byte_lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.bus_b[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = bus.bus_b;
            end
        endcase
    end

    assign st_en = !reset && !bus.flush && bus.enable && bus.mem_write;

    // Memory has no reset; the load path reads the pre-edge contents, so a
    // same-word load/store pair returns the old word.
    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int b = 0; b < 4; b++) begin
                if (st_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            wb_q         <= 1'b0;
            mem_to_reg_q <= 1'b0;
            halt_q       <= 1'b0;
            mem_result_q <= '0;
            alu_result_q <= '0;
            addr_wr_q    <= '0;
        end else if (bus.enable) begin
            wb_q         <= bus.ex_wb;
            mem_to_reg_q <= bus.ex_mem_to_reg;
            halt_q       <= bus.ex_halt;
            mem_result_q <= ld_data;
            alu_result_q <= bus.ex_alu_result;
            addr_wr_q    <= bus.ex_addr_wr;
        end
    end

    assign bus.wb         = wb_q;
    assign bus.mem_to_reg = mem_to_reg_q;
    assign bus.halt       = halt_q;
    assign bus.mem_result = mem_result_q;
    assign bus.alu_result = alu_result_q;
    assign bus.addr_wr    = addr_wr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dump_state_q <= DUMP_IDLE;
            dump_idx_q   <= '0;
        end else begin
            dump_state_q <= dump_state_d;
            dump_idx_q   <= dump_idx_d;
        end
    end

    always_comb begin
        dump_state_d = dump_state_q;
        dump_idx_d   = dump_idx_q;
        dump_valid   = 1'b0;
        dump_done    = 1'b0;
        case (dump_state_q)
            DUMP_IDLE: begin
                if (bus.dump_start) begin
                    dump_state_d = DUMP_SEND;
                    dump_idx_d   = '0;
                end
            end
            DUMP_SEND: begin
                dump_valid = 1'b1;
                if (bus.dump_ready) begin
                    if (dump_idx_q == LAST_IDX) begin
                        dump_state_d = DUMP_DONE;
                    end else begin
                        dump_idx_d = dump_idx_q + 1'b1;
                    end
                end
            end
            DUMP_DONE: begin
                dump_done    = 1'b1;
                dump_state_d = DUMP_IDLE;
            end
            default: dump_state_d = DUMP_IDLE;
        endcase
    end

    // Live read: a store to a word not yet sent shows up in the stream.
    assign bus.dump_valid = dump_valid;
    assign bus.dump_done  = dump_done;
    assign bus.dump_addr  = dump_valid ? dump_idx_q : '0;
    assign bus.dump_data  = dump_valid ? mem[dump_idx_q] : '0;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a byte-array reference model
module tb_mem_stage;
    localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LW = 3'b100;
    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if bus_if ();
    mem_stage dut (.clk(clk), .reset(reset), .bus(bus_if));

    int n_checks = 0;
    int n_errors = 0;

    // reference model: 1 KiB byte array with per-byte "written" flags
    logic [7:0]  bm [1024];
    bit          bk [1024];
    bit          m_seen = 1'b0;
    bit          m_rst  = 1'b0;
    logic        exp_wb, exp_m2r, exp_halt;
    logic [31:0] exp_mr, exp_alu;
    logic [4:0]  exp_aw;
    bit          exp_mr_known;

    // literal expectation handed from the stimulus to the compare process
    bit          lit_valid = 1'b0;
    string       lit_name;
    logic [31:0] lit_act, lit_exp;

    int          sb_idx = 0;
    int          done_count = 0;
    bit          prev_valid = 1'b0;
    bit          prev_done = 1'b0;
    logic [7:0]  prev_addr = '0;

    function automatic logic [31:0] word_at(input int w);
        return {bm[4*w+3], bm[4*w+2], bm[4*w+1], bm[4*w]};
    endfunction

    function automatic bit word_known(input int w);
        return bk[4*w] && bk[4*w+1] && bk[4*w+2] && bk[4*w+3];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : model
        int ba, w, h;
        logic [31:0] bb;
        logic [15:0] hv;
        logic [7:0]  bv;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_seen = 1'b1; m_rst = 1'b1;
                exp_wb = 0; exp_m2r = 0; exp_halt = 0;
                exp_mr = 0; exp_alu = 0; exp_aw = 0; exp_mr_known = 1'b1;
            end else begin
                m_rst = 1'b0;
                if (bus_if.flush) begin
                    exp_wb = 0; exp_m2r = 0; exp_halt = 0;
                    exp_mr = 0; exp_alu = 0; exp_aw = 0; exp_mr_known = 1'b1;
                end else if (bus_if.enable) begin
                    ba = int'(bus_if.ex_alu_result[9:0]);
                    w  = ba / 4;
                    h  = ba - (ba % 2);
                    bb = bus_if.bus_b;
                    if (bus_if.mem_rd_src[2]) exp_mr = word_at(w);
                    else if (bus_if.mem_rd_src[1]) begin
                        hv = {bm[h+1], bm[h]};
                        exp_mr = bus_if.mem_rd_src[0] ? {16'h0, hv} : {{16{hv[15]}}, hv};
                    end else begin
                        bv = bm[ba];
                        exp_mr = bus_if.mem_rd_src[0] ? {24'h0, bv} : {{24{bv[7]}}, bv};
                    end
                    exp_mr_known = word_known(w);
                    exp_wb = bus_if.ex_wb; exp_m2r = bus_if.ex_mem_to_reg; exp_halt = bus_if.ex_halt;
                    exp_alu = bus_if.ex_alu_result; exp_aw = bus_if.ex_addr_wr;
                    if (bus_if.mem_write) begin
                        if (bus_if.mem_wr_src[1]) begin
                            for (int k = 0; k < 4; k++) begin bm[4*w+k] = bb[8*k +: 8]; bk[4*w+k] = 1'b1; end
                        end else if (bus_if.mem_wr_src[0]) begin
                            for (int k = 0; k < 2; k++) begin bm[h+k] = bb[8*k +: 8]; bk[h+k] = 1'b1; end
                        end else begin
                            bm[ba] = bb[7:0]; bk[ba] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_seen) begin
                chk("wb", {31'b0, bus_if.wb}, {31'b0, exp_wb});
                chk("mem_to_reg", {31'b0, bus_if.mem_to_reg}, {31'b0, exp_m2r});
                chk("halt", {31'b0, bus_if.halt}, {31'b0, exp_halt});
                if (exp_mr_known) chk("mem_result", bus_if.mem_result, exp_mr);
                chk("alu_result", bus_if.alu_result, exp_alu);
                chk("addr_wr", {27'b0, bus_if.addr_wr}, {27'b0, exp_aw});
                if (m_rst) begin
                    chk("reset_dump_valid", {31'b0, bus_if.dump_valid}, 32'd0);
                    chk("reset_dump_done", {31'b0, bus_if.dump_done}, 32'd0);
                    chk("reset_dump_addr_data", bus_if.dump_data | {24'b0, bus_if.dump_addr}, 32'd0);
                    sb_idx = 0;
                end else begin
                    if (prev_valid && bus_if.dump_ready) begin
                        chk("dump_order", {24'b0, prev_addr}, 32'(sb_idx));
                        sb_idx++;
                    end
                    if (bus_if.dump_valid)
                        chk("dump_data", bus_if.dump_data, word_at(int'(bus_if.dump_addr)));
                    if (bus_if.dump_done) begin
                        chk("dump_word_count", 32'(sb_idx), 32'd256);
                        chk("dump_done_single", {31'b0, prev_done}, 32'd0);
                        done_count++;
                        sb_idx = 0;
                    end
                end
                prev_valid = bus_if.dump_valid;
                prev_addr  = bus_if.dump_addr;
                prev_done  = bus_if.dump_done;
            end
            if (lit_valid) chk(lit_name, lit_act, lit_exp);
        end
    end

    task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lit_name = nm; lit_act = act; lit_exp = exp; lit_valid = 1'b1;
        @(negedge clk); #1;
        lit_valid = 1'b0;
    endtask

    task automatic set_idle();
        bus_if.enable = 1'b0; bus_if.flush = 1'b0; bus_if.mem_write = 1'b0;
        bus_if.dump_start = 1'b0; bus_if.dump_ready = 1'b0;
    endtask

    task automatic rand_dp();
        bus_if.enable        = ($urandom_range(0, 9) != 0);
        bus_if.flush         = ($urandom_range(0, 9) == 0);
        bus_if.mem_rd_src    = 3'($urandom);
        bus_if.mem_wr_src    = 2'($urandom);
        bus_if.mem_write     = 1'($urandom);
        bus_if.ex_wb         = 1'($urandom);
        bus_if.ex_mem_to_reg = 1'($urandom);
        bus_if.ex_halt       = 1'($urandom);
        bus_if.bus_b         = $urandom;
        bus_if.ex_alu_result = $urandom;
        bus_if.ex_addr_wr    = 5'($urandom);
    endtask

    task automatic op(input logic [2:0] rs, input logic [1:0] ws, input logic mw,
                      input logic [31:0] bb, input logic [31:0] a, input logic en, input logic fl);
        bus_if.mem_rd_src = rs; bus_if.mem_wr_src = ws; bus_if.mem_write = mw;
        bus_if.bus_b = bb; bus_if.ex_alu_result = a; bus_if.enable = en; bus_if.flush = fl;
        bus_if.ex_wb = 1'b1; bus_if.ex_mem_to_reg = 1'b1;
        bus_if.ex_halt = 1'($urandom); bus_if.ex_addr_wr = 5'($urandom);
        @(negedge clk); #1;
        set_idle();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin : stimulus
        bit got_done;
        bit found;
        reset = 1'b1;
        rand_dp();
        bus_if.mem_write = 1'b1; bus_if.dump_start = 1'b1; bus_if.dump_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        post("reset_mem_result", bus_if.mem_result, 32'd0);
        reset = 1'b0;
        set_idle();
        @(negedge clk); #1;

        for (int w = 0; w < 256; w++) op(LW, SW, 1'b1, $urandom, 32'(w * 4), 1'b1, 1'b0);

        op(LW, SW, 1'b1, 32'h8000_00F0, 32'h10, 1'b1, 1'b0);
        op(LB, SW, 1'b0, 32'h0, 32'h10, 1'b1, 1'b0);
        post("lb_sign", bus_if.mem_result, 32'hFFFF_FFF0);
        op(LBU, SW, 1'b0, 32'h0, 32'h13, 1'b1, 1'b0);
        post("lbu_zero", bus_if.mem_result, 32'h0000_0080);
        op(LH, SW, 1'b0, 32'h0, 32'h12, 1'b1, 1'b0);
        post("lh_sign", bus_if.mem_result, 32'hFFFF_8000);

        op(LW, SW, 1'b1, 32'h0, 32'h20, 1'b1, 1'b0);
        op(LW, SB, 1'b1, 32'hFFFF_FFAB, 32'h21, 1'b1, 1'b0);
        op(LW, SW, 1'b0, 32'h0, 32'h20, 1'b1, 1'b0);
        post("sb_lane", bus_if.mem_result, 32'h0000_AB00);
        op(LW, SH, 1'b1, 32'hFFFF_1234, 32'h22, 1'b1, 1'b0);
        op(LW, SW, 1'b0, 32'h0, 32'h20, 1'b1, 1'b0);
        post("sh_lane", bus_if.mem_result, 32'h1234_AB00);

        op(LW, SW, 1'b1, 32'h1111_1111, 32'h30, 1'b1, 1'b0);
        op(LW, SW, 1'b1, 32'hDEAD_BEEF, 32'h30, 1'b1, 1'b1);
        post("flush_wb", {31'b0, bus_if.wb}, 32'd0);
        post("flush_mem_result", bus_if.mem_result, 32'd0);
        op(LW, SW, 1'b0, 32'h0, 32'h30, 1'b1, 1'b0);
        op(LW, SW, 1'b1, 32'h2222_2222, 32'h30, 1'b0, 1'b0);
        post("hold_mem_result", bus_if.mem_result, 32'h1111_1111);
        post("hold_wb", {31'b0, bus_if.wb}, 32'd1);
        op(LW, SW, 1'b0, 32'h0, 32'h30, 1'b1, 1'b0);
        post("no_store_when_blocked", bus_if.mem_result, 32'h1111_1111);

        op(LW, SW, 1'b1, 32'h0000_0077, 32'h40, 1'b1, 1'b0);
        op(LW, SW, 1'b1, 32'h0000_0099, 32'h40, 1'b1, 1'b0);
        post("load_sees_old_word", bus_if.mem_result, 32'h0000_0077);
        op(LW, SW, 1'b0, 32'h0, 32'h40, 1'b1, 1'b0);
        post("store_after_load", bus_if.mem_result, 32'h0000_0099);

        op(LW, SW, 1'b1, 32'h5, 32'h400, 1'b1, 1'b0);
        op(LW, SW, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        post("wrap_word0", bus_if.mem_result, 32'h5);
        op(LW, SW, 1'b1, 32'h66, 32'hFFFF_F3FC, 1'b1, 1'b0);
        op(LW, SW, 1'b0, 32'h0, 32'h3FC, 1'b1, 1'b0);
        post("wrap_word255", bus_if.mem_result, 32'h66);

        for (int c = 0; c < 1500; c++) begin
            rand_dp();
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk); #1;
        end
        reset = 1'b0;
        set_idle();
        @(negedge clk); #1;

        got_done = 1'b0;
        rand_dp();
        bus_if.dump_start = 1'b1;
        @(negedge clk); #1;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            rand_dp();
            bus_if.dump_ready = 1'($urandom);
            bus_if.dump_start = ($urandom_range(0, 31) == 0);
            @(negedge clk); #1;
            if (bus_if.dump_done) got_done = 1'b1;
        end
        set_idle();
        post("dump_finished", {31'b0, got_done}, 32'd1);
        post("dump_done_count", 32'(done_count), 32'd1);
        post("dump_idle_after", {31'b0, bus_if.dump_valid}, 32'd0);

        found = 1'b0;
        bus_if.dump_start = 1'b1; bus_if.dump_ready = 1'b1;
        @(negedge clk); #1;
        bus_if.dump_start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (bus_if.dump_valid && bus_if.dump_addr == 8'd100) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        set_idle();
        post("reached_index_100", {31'b0, found}, 32'd1);
        post("valid_after_reset", {31'b0, bus_if.dump_valid}, 32'd0);
        post("done_count_after_reset", 32'(done_count), 32'd1);

        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
